clic_irq_arbiter: RTL

CLIC-style interrupt arbiter for the 32-bit CV32A6 configuration with SCLIC enabled. It sits directly upstream of the core's interrupt input. Each cycle it latches up to `NumSrc` (256) interrupt sources into per-source pending state, applies enable, trigger type and level, and selects the winning source. The winner is presented to the core through a valid/ready handshake; the core's acceptance clears edge-triggered pending bits.

---
 rtl/clic_arb_pkg.sv | 26 ++
 rtl/clic_arb_tree.sv | 54 +++++
 rtl/clic_irq_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/clic_arb_pkg.sv
// Shared types and default sizes for the CLIC interrupt arbiter.
// CLIC_IRQ_ARB_SHV_EN adds the selective-hardware-vectoring bit to both structs.
package clic_arb_pkg;

  localparam int DefNumSrc     = 256;
  localparam int DefLevelWidth = 8;
  localparam int DefIdWidth    = $clog2(DefNumSrc);

  typedef struct packed {
    logic                     ie;
    logic                     trig_edge;  // 1 = rising edge, 0 = level
    logic [DefLevelWidth-1:0] level;
`ifdef CLIC_IRQ_ARB_SHV_EN
    logic                     shv;
`endif
  } clic_src_cfg_t;

  typedef struct packed {
    logic [DefIdWidth-1:0]    id;
    logic [DefLevelWidth-1:0] level;
`ifdef CLIC_IRQ_ARB_SHV_EN
    logic                     shv;
`endif
  } clic_irq_t;

endpackage

// File: rtl/clic_arb_tree.sv
// Combinational binary max-tree over {valid, level, id}; on equal levels the
// higher source ID wins. Leaves are padded up to a power of two.
module clic_arb_tree #(
  parameter int NumSrc     = 256,
  parameter int LevelWidth = 8,
  parameter int IdWidth    = $clog2(NumSrc)
) (
  input  logic [NumSrc-1:0]                 valid_i,
  input  logic [NumSrc-1:0][LevelWidth-1:0] level_i,
  output logic                              valid_o,
  output logic [LevelWidth-1:0]             level_o,
  output logic [IdWidth-1:0]                id_o
);

  localparam int NumLeaf = 1 << IdWidth;

  // Heap layout: node n has children 2n (lower IDs) and 2n+1 (higher IDs).
  logic                  node_valid [1:2*NumLeaf-1];
  logic [LevelWidth-1:0] node_level [1:2*NumLeaf-1];
  logic [IdWidth-1:0]    node_id    [1:2*NumLeaf-1];

  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    node_valid = '{default: 1'b0};
    node_level = '{default: '0};
    node_id    = '{default: '0};

    for (int l = 0; l < NumLeaf; l++) begin
      if (l < NumSrc) begin
        node_valid[NumLeaf + l] = valid_i[l];
        node_level[NumLeaf + l] = level_i[l];
        node_id[NumLeaf + l]    = IdWidth'(l);
      end
    end

    for (int n = NumLeaf - 1; n >= 1; n--) begin
      if (node_valid[2*n+1] &&
          (!node_valid[2*n] || node_level[2*n+1] >= node_level[2*n])) begin
        node_valid[n] = 1'b1;
        node_level[n] = node_level[2*n+1];
        node_id[n]    = node_id[2*n+1];
      end else begin
        node_valid[n] = node_valid[2*n];
        node_level[n] = node_level[2*n];
        node_id[n]    = node_id[2*n];
      end
    end
  end

  assign valid_o = node_valid[1];
  assign level_o = node_level[1];
  assign id_o    = node_id[1];

endmodule

// File: rtl/clic_irq_arbiter.sv
// CLIC-style interrupt arbiter: per-source pending/enable/trigger/level state,
// max-level arbitration and a registered valid/ready offer to the core.
// Optional CLIC_IRQ_ARB_SHV_EN adds per-source shv storage, cfg_shv_i and irq_shv_o.
// LevelWidth/IdWidth must match the widths used by the clic_arb_pkg structs.
module clic_irq_arbiter
  import clic_arb_pkg::*;
#(
  parameter int NumSrc     = DefNumSrc,
  parameter int LevelWidth = DefLevelWidth,
  parameter int IdWidth    = $clog2(NumSrc)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumSrc-1:0]     intr_src_i,
  input  logic                  cfg_we_i,
  input  logic [IdWidth-1:0]    cfg_idx_i,
  input  logic                  cfg_ie_i,
  input  logic                  cfg_edge_i,
  input  logic [LevelWidth-1:0] cfg_level_i,
`ifdef CLIC_IRQ_ARB_SHV_EN
  input  logic                  cfg_shv_i,
`endif
  input  logic [LevelWidth-1:0] thresh_i,
  output logic                  irq_valid_o,
  input  logic                  irq_ready_i,
  output logic [IdWidth-1:0]    irq_id_o,
  output logic [LevelWidth-1:0] irq_level_o
`ifdef CLIC_IRQ_ARB_SHV_EN
  ,
  output logic                  irq_shv_o
`endif
);

  clic_src_cfg_t                   cfg_q [NumSrc];
  logic [NumSrc-1:0]               ip_q, ip_d, src_q;
  logic [NumSrc-1:0]               cand;
  logic [NumSrc-1:0][LevelWidth-1:0] cand_level;

  logic                  win_valid;
  logic [LevelWidth-1:0] win_level;
  logic [IdWidth-1:0]    win_id;

  logic      irq_valid_q, irq_valid_d;
  clic_irq_t irq_q, irq_d;
  logic      handshake;

  assign handshake = irq_valid_q & irq_ready_i;

  // NOTE: the config array is a small register file with a reset, because every
  // source must come out of reset disabled; it cannot map onto a RAM macro.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumSrc; i++) begin
        cfg_q[i] <= '0;
      end
    end else if (cfg_we_i) begin
      cfg_q[cfg_idx_i].ie        <= cfg_ie_i;
      cfg_q[cfg_idx_i].trig_edge <= cfg_edge_i;
      cfg_q[cfg_idx_i].level     <= cfg_level_i;
`ifdef CLIC_IRQ_ARB_SHV_EN
      cfg_q[cfg_idx_i].shv       <= cfg_shv_i;
`endif
    end
  end

  always_comb begin
    ip_d       = '0;
    cand       = '0;
    cand_level = '0;
    for (int i = 0; i < NumSrc; i++) begin
      if (cfg_q[i].trig_edge) begin
        // A fresh rising edge wins over an acceptance clear in the same cycle.
        ip_d[i] = (intr_src_i[i] & ~src_q[i]) |
                  (ip_q[i] & ~(handshake && irq_q.id == IdWidth'(i)));
      end else begin
        ip_d[i] = intr_src_i[i];
      end
      if (cfg_we_i && cfg_idx_i == IdWidth'(i) && cfg_edge_i != cfg_q[i].trig_edge) begin
        ip_d[i] = 1'b0;
      end
      cand[i]       = ip_q[i] & cfg_q[i].ie;
      cand_level[i] = cfg_q[i].level;
    end
  end

  clic_arb_tree #(
    .NumSrc    (NumSrc),
    .LevelWidth(LevelWidth),
    .IdWidth   (IdWidth)
  ) u_tree (
    .valid_i(cand),
    .level_i(cand_level),
    .valid_o(win_valid),
    .level_o(win_level),
    .id_o   (win_id)
  );

  // The offer is blanked for one cycle after acceptance so the stale winner
  // is not re-presented while its pending clear takes effect.
  always_comb begin
    irq_valid_d = 1'b0;
    irq_d       = '0;
    if (win_valid && (win_level > thresh_i) && !handshake) begin
      irq_valid_d = 1'b1;
      irq_d.id    = win_id;
      irq_d.level = win_level;
`ifdef CLIC_IRQ_ARB_SHV_EN
      irq_d.shv   = cfg_q[win_id].shv;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ip_q        <= '0;
      src_q       <= '0;
      irq_valid_q <= 1'b0;
      irq_q       <= '0;
    end else begin
      ip_q        <= ip_d;
      src_q       <= intr_src_i;
      irq_valid_q <= irq_valid_d;
      irq_q       <= irq_d;
    end
  end

  assign irq_valid_o = irq_valid_q;
  assign irq_id_o    = irq_q.id;
  assign irq_level_o = irq_q.level;
`ifdef CLIC_IRQ_ARB_SHV_EN
  assign irq_shv_o   = irq_q.shv;
`endif

endmodule
